// File: rtl/std_reg_writer.sv
// std_reg_writer: issues one-cycle write_en writes to a std_reg target, waits for done,
// verifies readback and reports ack/err with bounded timeout and retry.
module std_reg_writer #(
   parameter int WIDTH     = 5,
   parameter int TIMEOUT   = 4,
   parameter int MAX_RETRY = 1,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   input  logic [WIDTH-1:0]     req_data,
   output logic                 req_ready,
   output logic [WIDTH-1:0]     reg_in,
   output logic                 reg_write_en,
   input  logic                 reg_done,
   input  logic [WIDTH-1:0]     reg_out,
   output logic                 ack,
   output logic                 err,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] write_count
);
   localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t state, state_n;
   logic [TW-1:0] timer;
   logic [RW-1:0] retry;
   logic ack_n, err_n, retry_n;

   assign req_ready    = state == IDLE;
   assign busy         = state != IDLE;
   assign reg_write_en = state == ISSUE;

   // reg_done takes priority over the timeout check in the same WAIT cycle
   always_comb begin
      state_n = state;
      ack_n   = 1'b0;
      err_n   = 1'b0;
      retry_n = 1'b0;
      case (state)
         IDLE:  state_n = req_valid ? ISSUE : IDLE;
         ISSUE: state_n = WAIT;
         WAIT: begin
            if (reg_done) begin
               state_n = IDLE;
               ack_n   = reg_out == reg_in;
               err_n   = reg_out != reg_in;
            end else if (timer == T_LAST) begin
               retry_n = retry != R_MAX;
               err_n   = retry == R_MAX;
               state_n = retry != R_MAX ? ISSUE : IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_in      <= '0;
         timer       <= '0;
         retry       <= '0;
         write_count <= '0;
         ack         <= 1'b0;
         err         <= 1'b0;
      end else begin
         ack <= ack_n;
         err <= err_n;
         if (state == IDLE && req_valid) begin
            reg_in <= req_data;
            retry  <= '0;
         end
         if (state == ISSUE) timer <= '0;
         else if (state == WAIT) timer <= timer + TW'(1);
         if (retry_n) retry <= retry + RW'(1);
         if (ack_n && !(&write_count)) write_count <= write_count + CNT_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_std_reg_writer.sv
// tb_std_reg_writer: directed checks of the writer against a behavioural std_reg target
// with selectable faults (stuck done, wrong readback, late done).
module tb_std_reg_writer;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic [4:0] req_data = '0;
   logic       req_ready, reg_write_en, ack, err, busy;
   logic [4:0] reg_in;
   logic [7:0] write_count;
   logic       req_ready2, reg_write_en2, ack2, err2, busy2;
   logic [4:0] reg_in2;
   logic [1:0] write_count2;
   logic       tgt_done = 1'b0;
   logic [4:0] tgt_out = '0;
   logic [1:0] dly = '0;
   int         mode = 0;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   std_reg_writer dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .reg_in(reg_in), .reg_write_en(reg_write_en),
      .reg_done(tgt_done), .reg_out(tgt_out), .ack(ack), .err(err), .busy(busy),
      .write_count(write_count));

   // Runs in lockstep with dut on the same target, only to exercise counter saturation
   std_reg_writer #(.CNT_WIDTH(2)) dut2 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready2), .reg_in(reg_in2), .reg_write_en(reg_write_en2),
      .reg_done(tgt_done), .reg_out(tgt_out), .ack(ack2), .err(err2), .busy(busy2),
      .write_count(write_count2));

   // mode 0 normal, 1 done stuck low, 2 readback forced to 0, 3 done delayed by 3 cycles
   always @(posedge clk) begin
      if (mode == 1) tgt_done <= 1'b0;
      else if (mode == 3) begin
         if (reg_write_en) begin
            tgt_out <= reg_in;
            dly <= 2'd3;
            tgt_done <= 1'b0;
         end else if (dly != 0) begin
            dly <= dly - 2'd1;
            tgt_done <= dly == 2'd1;
         end else tgt_done <= 1'b0;
      end else begin
         tgt_done <= reg_write_en;
         if (reg_write_en) tgt_out <= mode == 2 ? 5'd0 : reg_in;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      tick();
      reset = 1'b0;
      tick();
      // 1: reset state and single write
      chk("rst_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_we", reg_write_en, 0);
      chk("rst_ack_err", {ack, err}, 0);
      chk("rst_count", write_count, 0);
      chk("rst_reg_in", reg_in, 0);
      req_valid = 1'b1; req_data = 5'h13;
      tick();
      req_valid = 1'b0; req_data = 5'h00;
      chk("t1_we", reg_write_en, 1);
      chk("t1_reg_in", reg_in, 5'h13);
      chk("t1_ready", {req_ready, busy}, 2'b01);
      tick();
      chk("t1_wait", {reg_write_en, ack, err}, 0);
      tick();
      chk("t1_ack", {ack, err}, 2'b10);
      chk("t1_count", write_count, 1);
      chk("t1_ready_back", req_ready, 1);
      tick();
      chk("t1_ack_once", {ack, err}, 0);
      // 2: back-to-back with valid held
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         req_valid = 1'b1; req_data = 5'(i);
         tick();
         chk("t2_we", {reg_write_en, reg_in}, {1'b1, 5'(i)});
         tick();
         chk("t2_wait", {reg_write_en, ack}, 0);
         tick();
         chk("t2_ack", {ack, err, req_ready}, 3'b101);
      end
      req_valid = 1'b0;
      chk("t2_count", write_count, 3);
      chk("t2_tgt", tgt_out, 5'h03);
      // 3: done stuck low, one retry then err
      do_reset();
      mode = 1;
      req_valid = 1'b1; req_data = 5'h07;
      tick();
      req_valid = 1'b0;
      chk("t3_we1", reg_write_en, 1);
      for (int c = 2; c <= 11; c++) begin
         tick();
         chk($sformatf("t3_c%0d", c), {reg_write_en, ack, err, busy},
             {c == 6, 1'b0, c == 11, c <= 10});
      end
      tick();
      chk("t3_end", {err, req_ready}, 2'b01);
      chk("t3_count", write_count, 0);
      // 4: readback mismatch, then done on the last WAIT cycle
      mode = 2;
      req_valid = 1'b1; req_data = 5'h1F;
      tick();
      req_valid = 1'b0;
      chk("t4_we", reg_write_en, 1);
      tick();
      tick();
      chk("t4_err", {ack, err}, 2'b01);
      tick();
      chk("t4_after", {reg_write_en, err, req_ready}, 3'b001);
      chk("t4_count", write_count, 0);
      mode = 3;
      req_valid = 1'b1; req_data = 5'h0C;
      tick();
      req_valid = 1'b0;
      chk("t4_we2", reg_write_en, 1);
      for (int c = 2; c <= 5; c++) begin
         tick();
         chk($sformatf("t4_w%0d", c), {reg_write_en, ack, err, busy}, 4'b0001);
      end
      tick();
      chk("t4_late_ack", {ack, err}, 2'b10);
      chk("t4_late_count", write_count, 1);
      // 5: async reset during WAIT
      req_valid = 1'b1; req_data = 5'h15;
      tick();
      req_valid = 1'b0;
      tick();
      chk("t5_in_wait", {busy, write_count}, {1'b1, 8'd1});
      #2 reset = 1'b1;
      #1 chk("t5_async", {reg_write_en, ack, err, busy, write_count}, 0);
      tick();
      reset = 1'b0;
      mode = 0;
      tick();
      chk("t5_ready", req_ready, 1);
      req_valid = 1'b1; req_data = 5'h0A;
      tick();
      req_valid = 1'b0;
      chk("t5_we", {reg_write_en, reg_in}, {1'b1, 5'h0A});
      tick();
      tick();
      chk("t5_ack", {ack, err, write_count}, {2'b10, 8'd1});
      // 6: saturating 2-bit counter
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         req_valid = 1'b1; req_data = 5'(i + 8);
         tick();
         req_valid = 1'b0;
         tick();
         tick();
         chk($sformatf("t6_ack%0d", i), {ack2, err2}, 2'b10);
         chk($sformatf("t6_cnt%0d", i), write_count2, i > 3 ? 2'd3 : 2'(i));
         chk($sformatf("t6_wide%0d", i), write_count, 8'(i));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/std_reg_writer.md
# std_reg_writer

Initiator for the one-cycle `write_en`/`done` register-write handshake used by the team's `std_reg` family. It accepts write requests on a valid/ready port and drives a target register's `in`/`write_en`. It waits for the target's `done`, checks the target's `out` against the written value, and reports success or error. A single instance sits between a group controller and one target register, replacing ad-hoc write_en sequencing logic.

## Interface
Parameters:
- WIDTH, 5: data width; must equal the target register width.
- TIMEOUT, 4: maximum number of WAIT cycles per attempt; must be ≥1.
- MAX_RETRY, 1: number of re-issues after a timeout; 0 disables retry.
- CNT_WIDTH, 8: width of the successful-write counter.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- req_valid  in  1  request present.
- req_data  in  WIDTH  value to write.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid&req_ready.
- reg_in  out  WIDTH  connects to the target `in`; holds the captured request data.
- reg_write_en  out  1  connects to the target `write_en`.
- reg_done  in  1  from the target `done`.
- reg_out  in  WIDTH  from the target `out`; used as readback.
- ack  out  1  one-cycle pulse on verified write.
- err  out  1  one-cycle pulse on final timeout or readback mismatch.
- busy  out  1  high whenever state ≠ IDLE.
- write_count  out  CNT_WIDTH  count of acked writes; saturates at all-ones.

## Operation
State machine:
- IDLE:
  - req_ready=1.
  - On acceptance: capture req_data into the data register, clear the retry counter, go to ISSUE.
- ISSUE:
  - reg_write_en=1 for exactly one cycle, with reg_in = captured data.
  - Clear the timer, go to WAIT.
- WAIT:
  - reg_write_en=0.
  - If reg_done=1:
    - reg_out == captured data: set ack for the next cycle, increment write_count (saturating), go to IDLE.
    - Mismatch: set err for the next cycle, go to IDLE. No retry is performed on a mismatch.
  - Else if timer == TIMEOUT-1:
    - Retries remaining: increment the retry counter, go to ISSUE.
    - Otherwise: set err, go to IDLE.
  - Else: increment the timer.

Rules:
- reg_done is ignored outside WAIT.
- If reg_done arrives in the same cycle as the timeout, reg_done wins.
- ack and err are registered. They are never both high, and each lasts exactly one cycle.
- Data comparison is exact, over all WIDTH bits.
- reg_write_en, req_ready and busy are decoded from the state register only.
- Reset values: state IDLE; reg_in, data register, timer, retry counter, write_count, ack and err all 0; reg_write_en 0; busy 0.
- req_ready=1 immediately after reset deassertion.
- Reset asserted mid-operation abandons the write without ack or err.

## Timing
Nominal latency against a standard one-cycle-latency register:
- Acceptance edge E0.
- Cycle 1: ISSUE, write_en=1.
- Edge E1: the target latches the data.
- Cycle 2: WAIT, target done=1 and out=data.
- Edge E2: the writer samples done and out.
- Cycle 3: ack=1, req_ready=1.
- Next acceptance possible at E3, giving a throughput of one write per 3 cycles.

Bounds:
- Per attempt, WAIT lasts at most TIMEOUT cycles.
- Worst case, an error is reported (1+TIMEOUT)·(1+MAX_RETRY)+1 cycles after acceptance.
- req_data may change freely after acceptance; reg_in stays stable until the next acceptance.

## Test plan
All scenarios use WIDTH=5, TIMEOUT=4, MAX_RETRY=1 and a behavioural std_reg target unless noted.
1. Reset, then a single request with 0x13 -> write_en high for exactly 1 cycle with reg_in=0x13; ack high in the 2nd cycle after that; write_count=1; err never asserted.
2. req_valid held with 0x01, 0x02, 0x03 presented back-to-back -> accepted every 3 cycles; 3 acks; write_count=3; target out ends at 0x03.
3. Target whose done is tied to 0 -> write_en pulses twice, 5 cycles apart; err pulses once, 4 WAIT cycles after the second pulse; write_count unchanged; req_ready returns to 1.
4. Request 0x1F, target returns out=0x00 with done -> err for one cycle; no second write_en; write_count unchanged. Then delay done by 3 cycles (arriving on the last WAIT cycle) -> ack, not err.
5. Reset asserted during WAIT -> write_en, ack, err, busy and write_count go to 0 without waiting for a clock edge. After release, request 0x0A -> normal ack, write_count=1.
6. CNT_WIDTH=2, 5 successful writes -> write_count reads 1, 2, 3, 3, 3.
